// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, fault codes, instruction size.
package cpu_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2
    } fault_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the CPU core and the PC fetch unit.
//   master : core side, drives run/stall/halt/branch/jump, observes PC and status
//   slave  : fetch unit side
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 32
);
    logic              run_i;
    logic              stall_i;
    logic              halt_i;
    logic              branch_taken_i;
    logic [ADDR_W-1:0] branch_off_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_tgt_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus4_o;
    logic              fetch_valid_o;
    logic              halted_o;
    logic [1:0]        fault_o;
    logic [CNT_W-1:0]  retired_o;

    modport master (
        output run_i, stall_i, halt_i, branch_taken_i, branch_off_i, jump_i, jump_tgt_i,
        input  pc_o, pc_plus4_o, fetch_valid_o, halted_o, fault_o, retired_o
    );

    modport slave (
        input  run_i, stall_i, halt_i, branch_taken_i, branch_off_i, jump_i, jump_tgt_i,
        output pc_o, pc_plus4_o, fetch_valid_o, halted_o, fault_o, retired_o
    );
endinterface

// File: rtl/pc_fetch_unit_next_calc.sv
// Combinational next-PC candidate and fault classification.
//   pc_i            current PC
//   jump_i/tgt      absolute jump (highest priority)
//   branch_taken_i  PC-relative branch with signed offset branch_off_i
//   next_pc_o       candidate next PC (truncated to ADDR_W)
//   fault_o         FLT_MISALIGN beats FLT_RANGE; FLT_NONE when legal
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_tgt_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_off_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output fault_e            fault_o
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [SUM_W-1:0] seq_sum;
    logic [SUM_W-1:0] br_sum;
    logic [SUM_W-1:0] cand;
    logic             in_limit;

    // Extra top bit flags negative results and carries out of ADDR_W alike.
    always_comb begin
        seq_sum = {1'b0, pc_i} + SUM_W'(INSTR_BYTES);
        br_sum  = $signed({1'b0, pc_i}) + $signed({branch_off_i[ADDR_W-1], branch_off_i});

        if (jump_i) begin
            cand = {1'b0, jump_tgt_i};
        end else if (branch_taken_i) begin
            cand = br_sum;
        end else begin
            cand = seq_sum;
        end

        next_pc_o = cand[ADDR_W-1:0];
        in_limit  = (32'(cand[ADDR_W-1:0]) + 32'd3) < MEM_BYTES;

        if (cand[1:0] != 2'b00) begin
            fault_o = FLT_MISALIGN;
        end else if (cand[ADDR_W] || !in_limit) begin
            fault_o = FLT_RANGE;
        end else begin
            fault_o = FLT_NONE;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the instruction memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pc_fetch_unit_if (controls in, PC/status out)
// FSM IDLE -> RUN on run_i; RUN -> HALT on halt_i or a fetch fault; HALT exits only by reset.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned CNT_W     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_unit_if.slave bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    fault_e            fault_q, fault_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [ADDR_W-1:0] next_pc;
    fault_e            next_fault;
    logic [CNT_W-1:0]  retired_inc;

    pc_next_calc #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_next_calc (
        .pc_i           (pc_q),
        .jump_i         (bus.jump_i),
        .jump_tgt_i     (bus.jump_tgt_i),
        .branch_taken_i (bus.branch_taken_i),
        .branch_off_i   (bus.branch_off_i),
        .next_pc_o      (next_pc),
        .fault_o        (next_fault)
    );

    // Saturating retire count.
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // Next-state: stall beats halt, halt beats PC update; a faulting target halts without retiring.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        retired_d = retired_q;

        unique case (state_q)
            IDLE: begin
                if (bus.run_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.stall_i) begin
                    if (bus.halt_i) begin
                        state_d   = HALT;
                        retired_d = retired_inc;
                    end else if (next_fault != FLT_NONE) begin
                        state_d = HALT;
                        fault_d = next_fault;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_inc;
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= ADDR_W'(RESET_PC);
            fault_q   <= FLT_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    // Status outputs are pure decodes of registered state.
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_q + ADDR_W'(INSTR_BYTES);
    assign bus.fetch_valid_o = (state_q == RUN);
    assign bus.halted_o      = (state_q == HALT);
    assign bus.fault_o       = fault_q;
    assign bus.retired_o     = retired_q;

endmodule
